// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the UART rx frame decoder: header bytes, FSM
// encoding, word-count limit, INSTR field positions and the LRC step.
package rx_pkt_pkg;

  localparam logic [7:0] HDR_FRAME      = 8'hA5;
  localparam logic [7:0] HDR_RE_TX_RESP = 8'hEE;
  localparam logic [7:0] HDR_RE_TX_REQ  = 8'hCE;

  // INSTR carries the word count in its high nibble, so 15 is the ceiling.
  localparam int MAX_WORDS_LIMIT = 15;

  localparam int INSTR_CNT_MSB = 7;
  localparam int INSTR_CNT_LSB = 4;
  localparam int INSTR_OP_MSB  = 3;
  localparam int INSTR_OP_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_INSTR = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_GET_LRC   = 3'd3,
    ST_CHECK     = 3'd4
  } state_t;

  // LRC is a plain XOR over the data bytes.
  function automatic logic [7:0] lrc_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/rx_packet_decoder_if.sv
// Word output stream of the frame decoder.
// Handshake: a word moves on every rising clock edge where o_Word_Valid and
// i_Word_Ready are both high; while o_Word_Valid is high and i_Word_Ready is
// low, o_Word and o_Word_Last hold steady; i_Word_Ready is ignored while
// o_Word_Valid is low.
interface rx_packet_decoder_if #(
  parameter int W = 16
);
  logic         o_Word_Valid;
  logic         i_Word_Ready;
  logic [W-1:0] o_Word;
  logic         o_Word_Last;

  modport master (
    output o_Word_Valid,
    output o_Word,
    output o_Word_Last,
    input  i_Word_Ready
  );

  modport slave (
    input  o_Word_Valid,
    input  o_Word,
    input  o_Word_Last,
    output i_Word_Ready
  );
endinterface

// File: rtl/rx_packet_decoder_word_stage.sv
// Staging RAM for one frame: byte-lane writes from the parser, asynchronous
// indexed read for the output stream.
module rx_word_stage #(
  parameter int BPW   = 2,
  parameter int DEPTH = 15,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LW    = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic                 i_Clock,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [LW-1:0]        wr_lane,
  input  logic [7:0]           wr_byte,
  input  logic [AW-1:0]        rd_addr,
  output logic [8*BPW-1:0]     rd_word
);

  logic [8*BPW-1:0] mem [0:(2**AW)-1];

  // Write a single byte lane of the addressed word.
  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      for (int l = 0; l < BPW; l++) begin
        if (wr_lane == LW'(l)) begin
          mem[wr_addr][l*8 +: 8] <= wr_byte;
        end
      end
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/rx_packet_decoder.sv
// UART rx frame decoder: parses {HDR, INSTR, data, LRC}, stages the data
// words and releases them on a valid/ready stream once the LRC checks out.
// Optional build macro RX_TIMEOUT_EN adds an inter-byte timeout.
module rx_packet_decoder
  import rx_pkt_pkg::*;
#(
  parameter int         BYTES_PER_WORD = 2,
  parameter int         MAX_WORDS      = 15,
  parameter logic [7:0] RX_FRAME_HDR   = HDR_FRAME,
  parameter logic [7:0] RE_TX_RESP_HDR = HDR_RE_TX_RESP,
  parameter int         TIMEOUT_CLKS   = 4340
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Rx_Valid,
  input  logic [7:0]                 i_Rx_Byte,
  rx_packet_decoder_if.master        word_if,
  output logic [3:0]                 o_Word_Cnt,
  output logic [3:0]                 o_Opcode,
  output logic                       o_Frame_Done,
  output logic                       o_Send_Re_Tx,
  output logic                       o_Re_Tx_Resp,
  output logic                       o_Overrun,
  output state_t                     o_Fsm_State
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int LW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [7:0]    lrc_q, lrc_d;
  logic [7:0]    lrc_rx_q, lrc_rx_d;

  logic          wr_en;
  logic          commit;
  logic          idle_in;
  logic          done_d, retx_d, resp_d, ovr_d;
  logic          timeout_hit;

  logic          rd_full_q;
  logic [AW-1:0] rd_ptr_q;
  logic [W-1:0]  rd_word;
  logic          rd_last;

  rx_word_stage #(
    .BPW   (BYTES_PER_WORD),
    .DEPTH (MAX_WORDS),
    .AW    (AW),
    .LW    (LW)
  ) u_stage (
    .i_Clock (i_Clock),
    .wr_en   (wr_en),
    .wr_addr (widx_q),
    .wr_lane (lane_q),
    .wr_byte (i_Rx_Byte),
    .rd_addr (rd_ptr_q),
    .rd_word (rd_word)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_q;

  // Clocks since the last received byte, saturating at the limit.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Rx_Valid) begin
      tmo_q <= '0;
    end else if (tmo_q != TW'(TIMEOUT_CLKS)) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign timeout_hit = (tmo_q == TW'(TIMEOUT_CLKS));
`else
  assign timeout_hit = 1'b0;
`endif

  // Parser next-state, staging writes and pulse requests.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    widx_d   = widx_q;
    lane_d   = lane_q;
    lrc_d    = lrc_q;
    lrc_rx_d = lrc_rx_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    idle_in  = 1'b0;
    done_d   = 1'b0;
    retx_d   = 1'b0;
    resp_d   = 1'b0;
    ovr_d    = 1'b0;

    case (state_q)
      ST_IDLE: idle_in = 1'b1;

      ST_GET_INSTR: begin
        if (i_Rx_Valid) begin
          cnt_d  = i_Rx_Byte[INSTR_CNT_MSB:INSTR_CNT_LSB];
          op_d   = i_Rx_Byte[INSTR_OP_MSB:INSTR_OP_LSB];
          widx_d = '0;
          lane_d = '0;
          lrc_d  = 8'h00;
          if (i_Rx_Byte[INSTR_CNT_MSB:INSTR_CNT_LSB] > 4'(MAX_WORDS)) begin
            retx_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (i_Rx_Byte[INSTR_CNT_MSB:INSTR_CNT_LSB] == 4'd0) begin
            state_d = ST_GET_LRC;
          end else begin
            state_d = ST_GET_DATA;
          end
        end
      end

      ST_GET_DATA: begin
        if (i_Rx_Valid) begin
          wr_en = 1'b1;
          lrc_d = lrc_next(lrc_q, i_Rx_Byte);
          if (lane_q == LW'(BYTES_PER_WORD - 1)) begin
            lane_d = '0;
            if (4'(widx_q) == cnt_q - 4'd1) begin
              state_d = ST_GET_LRC;
            end else begin
              widx_d = widx_q + AW'(1);
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end

      ST_GET_LRC: begin
        if (i_Rx_Valid) begin
          lrc_rx_d = i_Rx_Byte;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        idle_in = 1'b1;
        if (lrc_rx_q == lrc_q) begin
          commit = 1'b1;
          done_d = 1'b1;
        end else begin
          retx_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit && !i_Rx_Valid &&
        (state_q == ST_GET_INSTR || state_q == ST_GET_DATA || state_q == ST_GET_LRC)) begin
      retx_d  = 1'b1;
      state_d = ST_IDLE;
    end

    // A byte landing in CHECK is treated as IDLE input; a commit of a
    // non-empty frame in that same cycle already owns the read side.
    if (idle_in && i_Rx_Valid) begin
      if (i_Rx_Byte == RX_FRAME_HDR) begin
        if (rd_full_q || (commit && cnt_q != 4'd0)) begin
          ovr_d = 1'b1;
        end else begin
          state_d = ST_GET_INSTR;
        end
      end else if (i_Rx_Byte == RE_TX_RESP_HDR) begin
        resp_d = 1'b1;
      end else begin
        retx_d = 1'b1;
      end
    end
  end

  // Parser registers and registered pulse outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      widx_q       <= '0;
      lane_q       <= '0;
      lrc_q        <= '0;
      lrc_rx_q     <= '0;
      o_Frame_Done <= 1'b0;
      o_Send_Re_Tx <= 1'b0;
      o_Re_Tx_Resp <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      widx_q       <= widx_d;
      lane_q       <= lane_d;
      lrc_q        <= lrc_d;
      lrc_rx_q     <= lrc_rx_d;
      o_Frame_Done <= done_d;
      o_Send_Re_Tx <= retx_d;
      o_Re_Tx_Resp <= resp_d;
      o_Overrun    <= ovr_d;
    end
  end

  // Read side: committed frame info, read pointer and full flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rd_full_q  <= 1'b0;
      rd_ptr_q   <= '0;
      o_Word_Cnt <= '0;
      o_Opcode   <= '0;
    end else if (commit) begin
      o_Word_Cnt <= cnt_q;
      o_Opcode   <= op_q;
      rd_ptr_q   <= '0;
      rd_full_q  <= (cnt_q != 4'd0);
    end else if (rd_full_q && word_if.i_Word_Ready) begin
      if (rd_last) begin
        rd_full_q <= 1'b0;
        rd_ptr_q  <= '0;
      end else begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign rd_last              = (4'(rd_ptr_q) == o_Word_Cnt - 4'd1);
  assign word_if.o_Word_Valid = rd_full_q;
  assign word_if.o_Word       = rd_full_q ? rd_word : '0;
  assign word_if.o_Word_Last  = rd_full_q && rd_last;
  assign o_Fsm_State          = state_q;

endmodule

// File: tb/tb_rx_packet_decoder.sv
// Directed bench for rx_packet_decoder (BPW=2, MAX_WORDS=8).
module tb_rx_packet_decoder;
  import rx_pkt_pkg::*;

  localparam int W = 16;
  localparam int TMO = 4340;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_Valid = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic [3:0] o_Word_Cnt, o_Opcode;
  logic       o_Frame_Done, o_Send_Re_Tx, o_Re_Tx_Resp, o_Overrun;
  state_t     o_Fsm_State;

  rx_packet_decoder_if #(.W(W)) word_if ();

  rx_packet_decoder #(
    .BYTES_PER_WORD (2),
    .MAX_WORDS      (8),
    .RX_FRAME_HDR   (8'hA5),
    .RE_TX_RESP_HDR (8'hEE),
    .TIMEOUT_CLKS   (TMO)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Rx_Valid   (i_Rx_Valid),
    .i_Rx_Byte    (i_Rx_Byte),
    .word_if      (word_if),
    .o_Word_Cnt   (o_Word_Cnt),
    .o_Opcode     (o_Opcode),
    .o_Frame_Done (o_Frame_Done),
    .o_Send_Re_Tx (o_Send_Re_Tx),
    .o_Re_Tx_Resp (o_Re_Tx_Resp),
    .o_Overrun    (o_Overrun),
    .o_Fsm_State  (o_Fsm_State)
  );

  // Clock and reset
  always #5 i_Clock = ~i_Clock;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, retx_cnt = 0, resp_cnt = 0, ovr_cnt = 0;
  bit valid_seen = 1'b0;
  logic [W:0] exp_q[$];   // {last, word}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_Valid = 1'b1;
    i_Rx_Byte  = b;
    tick();
    i_Rx_Valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard and pulse monitor, sampled on the falling edge.
  always @(negedge i_Clock) begin
    if (!i_Reset) begin
      if (o_Frame_Done) done_cnt++;
      if (o_Send_Re_Tx) retx_cnt++;
      if (o_Re_Tx_Resp) resp_cnt++;
      if (o_Overrun)    ovr_cnt++;
      if (word_if.o_Word_Valid) valid_seen = 1'b1;
      if (word_if.o_Word_Valid && word_if.i_Word_Ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_extra_word observed=%h expected=none", word_if.o_Word);
        end else begin
          chk("sb_word", {15'd0, word_if.o_Word_Last, word_if.o_Word}, {15'd0, exp_q.pop_front()});
        end
      end
    end
  end

  int d0, r0, o0, p0;

  initial begin
    word_if.i_Word_Ready = 1'b1;
    wait_cycles(3);
    i_Reset = 1'b0;

    // Reset state
    chk("rst_state", 32'(o_Fsm_State), 32'(ST_IDLE));
    chk("rst_valid", 32'(word_if.o_Word_Valid), 0);
    chk("rst_word", 32'(word_if.o_Word), 0);
    chk("rst_cnt", 32'(o_Word_Cnt), 0);
    chk("rst_op", 32'(o_Opcode), 0);
    chk("rst_pulses", {28'd0, o_Frame_Done, o_Send_Re_Tx, o_Re_Tx_Resp, o_Overrun}, 0);

    // Test 1: good two-word frame, latency and ordering
    d0 = done_cnt; r0 = retx_cnt;
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'h5678});
    send_byte(8'hA5); send_byte(8'h21); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h08);
    chk("t1_check_state", 32'(o_Fsm_State), 32'(ST_CHECK));
    chk("t1_valid_early", 32'(word_if.o_Word_Valid), 0);
    tick();
    chk("t1_valid", 32'(word_if.o_Word_Valid), 1);
    chk("t1_word0", 32'(word_if.o_Word), 32'h1234);
    chk("t1_last0", 32'(word_if.o_Word_Last), 0);
    chk("t1_done_pulse", 32'(o_Frame_Done), 1);
    chk("t1_cnt", 32'(o_Word_Cnt), 2);
    chk("t1_op", 32'(o_Opcode), 1);
    tick();
    chk("t1_word1", 32'(word_if.o_Word), 32'h5678);
    chk("t1_last1", 32'(word_if.o_Word_Last), 1);
    tick();
    chk("t1_valid_drop", 32'(word_if.o_Word_Valid), 0);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_retx_count", 32'(retx_cnt - r0), 0);

    // Test 2: bad LRC
    d0 = done_cnt; r0 = retx_cnt; valid_seen = 1'b0;
    send_byte(8'hA5); send_byte(8'h25); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h09);
    wait_cycles(4);
    chk("t2_retx_count", 32'(retx_cnt - r0), 1);
    chk("t2_done_count", 32'(done_cnt - d0), 0);
    chk("t2_no_valid", 32'(valid_seen), 0);
    chk("t2_op_kept", 32'(o_Opcode), 1);
    chk("t2_cnt_kept", 32'(o_Word_Cnt), 2);

    // Test 3: consumer stall, header refused while words pending
    word_if.i_Word_Ready = 1'b0;
    o0 = ovr_cnt; r0 = retx_cnt;
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'h5678});
    send_byte(8'hA5); send_byte(8'h21); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h08);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_word", 32'(word_if.o_Word), 32'h1234);
      chk("t3_hold_valid", 32'(word_if.o_Word_Valid), 1);
      if (i == 2) send_byte(8'hA5);
      else tick();
    end
    chk("t3_overrun", 32'(ovr_cnt - o0), 1);
    chk("t3_state_idle", 32'(o_Fsm_State), 32'(ST_IDLE));
    chk("t3_no_retx", 32'(retx_cnt - r0), 0);
    word_if.i_Word_Ready = 1'b1;
    for (int k = 0; k < 10 && word_if.o_Word_Valid; k++) tick();
    chk("t3_drained", 32'(word_if.o_Word_Valid), 0);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // Test 4: empty frame, stray byte, retransmit response
    valid_seen = 1'b0; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    tick();
    chk("t4_done_pulse", 32'(o_Frame_Done), 1);
    chk("t4_cnt", 32'(o_Word_Cnt), 0);
    chk("t4_op", 32'(o_Opcode), 3);
    wait_cycles(3);
    chk("t4_no_valid", 32'(valid_seen), 0);
    chk("t4_done_count", 32'(done_cnt - d0), 1);
    r0 = retx_cnt; p0 = resp_cnt;
    send_byte(8'h3C);
    tick();
    chk("t4_stray_retx", 32'(retx_cnt - r0), 1);
    send_byte(8'hEE);
    tick();
    chk("t4_resp", 32'(resp_cnt - p0), 1);
    chk("t4_resp_no_retx", 32'(retx_cnt - r0), 1);

    // Test 5: word count above MAX_WORDS, then a good frame
    send_byte(8'hA5); send_byte(8'hF0);
    chk("t5_retx_pulse", 32'(o_Send_Re_Tx), 1);
    chk("t5_state_idle", 32'(o_Fsm_State), 32'(ST_IDLE));
    d0 = done_cnt;
    exp_q.push_back({1'b1, 16'hCDAB});
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h66);
    wait_cycles(4);
    chk("t5_done_count", 32'(done_cnt - d0), 1);
    chk("t5_cnt", 32'(o_Word_Cnt), 1);
    chk("t5_op", 32'(o_Opcode), 2);

    // Test 6: reset mid-frame, then a clean frame
    d0 = done_cnt; r0 = retx_cnt;
    send_byte(8'hA5); send_byte(8'h21); send_byte(8'h34); send_byte(8'h12); send_byte(8'h78);
    i_Reset = 1'b1;
    wait_cycles(2);
    i_Reset = 1'b0;
    chk("t6_state_idle", 32'(o_Fsm_State), 32'(ST_IDLE));
    chk("t6_valid", 32'(word_if.o_Word_Valid), 0);
    chk("t6_cnt_clr", 32'(o_Word_Cnt), 0);
    chk("t6_op_clr", 32'(o_Opcode), 0);
    chk("t6_no_pulses", 32'((done_cnt - d0) + (retx_cnt - r0)), 0);
    exp_q.push_back({1'b1, 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'h51);
    wait_cycles(4);
    chk("t6_done_count", 32'(done_cnt - d0), 1);
    chk("t6_cnt", 32'(o_Word_Cnt), 1);
    chk("t6_op", 32'(o_Opcode), 1);

`ifdef RX_TIMEOUT_EN
    // Inter-byte timeout mid-frame
    r0 = retx_cnt;
    send_byte(8'hA5); send_byte(8'h21); send_byte(8'h34);
    wait_cycles(TMO + 5);
    chk("tmo_retx", 32'(retx_cnt - r0), 1);
    chk("tmo_state_idle", 32'(o_Fsm_State), 32'(ST_IDLE));
`endif

    wait_cycles(2);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
